// File: rtl/btn_pkg.sv
// Shared constants, counter-width helper and repeat-phase type for the button debouncer.
package btn_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms @ 100 MHz
  localparam int DEF_REPEAT_DELAY    = 50_000_000;
  localparam int DEF_REPEAT_PERIOD   = 10_000_000;

  // Bits needed to hold the values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  typedef enum logic {
    RPT_FIRST = 1'b0,
    RPT_NEXT  = 1'b1
  } rpt_phase_t;

endpackage

// File: rtl/btn_debounce_if.sv
// Button channel bundle: raw pins in, debounced level and press strobe out.
interface btn_debounce_if #(
  parameter int N = 1
);
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_lvl;
  logic [N-1:0] btn_pulse;

  modport master (output btn_in, input btn_lvl, input btn_pulse);
  modport slave  (input btn_in, output btn_lvl, output btn_pulse);
endinterface

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, level and press strobe.
// Auto-repeat strobes are built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic           CLK,
  input logic           RSTN,
  btn_debounce_if.slave bus
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debounce_ch: cycle parameters must be at least 1");
  end

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             pulse_q, pulse_d;
  logic             sample;
  logic             toggle;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  rpt_phase_t       rpt_phase_q, rpt_phase_d;
  logic [RPT_W-1:0] rpt_last;

  assign rpt_last = (rpt_phase_q == RPT_FIRST) ? RPT_DELAY_LAST : RPT_PERIOD_LAST;
`endif

  assign sync_d = {sync_q[0], bus.btn_in};
  assign sample = sync_q[1];
  assign toggle = (sample != lvl_q) && (cnt_q == CNT_LAST);

  // NOTE: every next-state signal gets a default on entry, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    pulse_d = 1'b0;

    if ((sample == lvl_q) || toggle) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Only the rising toggle strobes; a release just drops the level.
    if (toggle) begin
      lvl_d   = ~lvl_q;
      pulse_d = ~lvl_q;
    end

`ifdef BTN_AUTOREPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;

    // The toggle edge itself never repeats; it either is the press or the release.
    if (toggle || !lvl_q) begin
      rpt_cnt_d   = '0;
      rpt_phase_d = RPT_FIRST;
    end else if (rpt_cnt_q == rpt_last) begin
      pulse_d     = 1'b1;
      rpt_cnt_d   = '0;
      rpt_phase_d = RPT_NEXT;
    end else begin
      rpt_cnt_d   = rpt_cnt_q + 1'b1;
    end
`endif
  end

  // NOTE: reset is synchronous (sampled only on the clock edge) and all state
  // updates use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      lvl_q       <= 1'b0;
      pulse_q     <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q   <= '0;
      rpt_phase_q <= RPT_FIRST;
`endif
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      lvl_q       <= lvl_d;
      pulse_q     <= pulse_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
`endif
    end
  end

  assign bus.btn_lvl   = lvl_q;
  assign bus.btn_pulse = pulse_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer: NUM_BTN independent btn_debounce_ch instances.
// Optional auto-repeat strobes: define BTN_AUTOREPEAT_EN.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [NUM_BTN-1:0] BTN_IN,
  output logic [NUM_BTN-1:0] BTN_LVL,
  output logic [NUM_BTN-1:0] BTN_PULSE
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_if #(.N(1)) ch_if ();

    assign ch_if.btn_in  = BTN_IN[i];
    assign BTN_LVL[i]    = ch_if.btn_lvl;
    assign BTN_PULSE[i]  = ch_if.btn_pulse;

    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .CLK  (CLK),
      .RSTN (RSTN),
      .bus  (ch_if.slave)
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus random bouncing
// pins compared against a window-based reference model.
module tb_btn_debounce;

  localparam int NB   = 3;
  localparam int DC   = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;
  localparam int MAXE = 16384;

  logic CLK = 1'b0;
  logic RSTN;
  int   n_tests = 0;
  int   n_fail  = 0;

  btn_debounce_if #(.N(NB)) tb_if ();

  btn_debounce #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .BTN_IN    (tb_if.btn_in),
    .BTN_LVL   (tb_if.btn_lvl),
    .BTN_PULSE (tb_if.btn_pulse)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // History of pins and reset per rising edge; the level flips once the
  // synchronized pin has disagreed with it on DC consecutive non-reset edges.
  logic [NB-1:0] pin_h [MAXE];
  bit            rst_h [MAXE];
  logic [NB-1:0] exp_lvl   = '0;
  logic [NB-1:0] exp_pulse = '0;
  int            e = 0;
`ifdef BTN_AUTOREPEAT_EN
  int            last_p  [NB];
  bit            first_r [NB];
`endif

  // Synchronized pin value seen at edge k (two edges of latency, zero after reset).
  function automatic logic samp(input int k, input int ch);
    if (k < 3) return 1'b0;
    if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
    return pin_h[k-2][ch];
  endfunction

  always @(posedge CLK) begin
    bit ok;
    if (e < MAXE - 1) e++;
    rst_h[e] = !RSTN;
    pin_h[e] = tb_if.btn_in;
    for (int ch = 0; ch < NB; ch++) begin
      ok = !rst_h[e] && (e >= DC);
      for (int j = 0; j < DC; j++) begin
        if (ok && (rst_h[e-j] || samp(e - j, ch) == exp_lvl[ch])) ok = 1'b0;
      end
      exp_pulse[ch] = 1'b0;
      if (rst_h[e]) begin
        exp_lvl[ch] = 1'b0;
      end else if (ok) begin
        exp_lvl[ch] = !exp_lvl[ch];
        if (exp_lvl[ch]) begin
          exp_pulse[ch] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          last_p[ch]  = e;
          first_r[ch] = 1'b1;
`endif
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      else if (exp_lvl[ch] && (e - last_p[ch] == (first_r[ch] ? RD : RP))) begin
        exp_pulse[ch] = 1'b1;
        last_p[ch]    = e;
        first_r[ch]   = 1'b0;
      end
`endif
    end
  end

  // Is a strobe expected k cycles after the press strobe (k >= 0)?
  function automatic bit exp_rep(input int k);
`ifdef BTN_AUTOREPEAT_EN
    return (k == 0) || (k >= RD && (k - RD) % RP == 0);
`else
    return k == 0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    tb_if.btn_in = '0;
    repeat (n) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RSTN = 1'b0;
    tb_if.btn_in = '1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      n_tests++;
      if (tb_if.btn_lvl !== '0 || tb_if.btn_pulse !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: lvl=%b pulse=%b, want 000/000", n, tb_if.btn_lvl, tb_if.btn_pulse);
      end
    end
    tb_if.btn_in = '0;
    RSTN = 1'b1;
    idle(8);
  endtask

  task automatic test_clean_press();
    tb_if.btn_in[0] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      n_tests++;
      if (tb_if.btn_lvl[0] !== (n >= 6) || tb_if.btn_pulse[0] !== ((n >= 6) && exp_rep(n - 6))) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: lvl=%b pulse=%b, want lvl=%b pulse=%b", n,
                 tb_if.btn_lvl[0], tb_if.btn_pulse[0], n >= 6, (n >= 6) && exp_rep(n - 6));
      end
    end
    tb_if.btn_in[0] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      n_tests++;
      if (tb_if.btn_lvl[0] !== (n < 6) || tb_if.btn_pulse[0] !== ((n < 6) && exp_rep(14 + n))) begin
        n_fail++;
        $display("FAIL clean_release edge %0d: lvl=%b pulse=%b, want lvl=%b pulse=%b", n,
                 tb_if.btn_lvl[0], tb_if.btn_pulse[0], n < 6, (n < 6) && exp_rep(14 + n));
      end
    end
    idle(4);
  endtask

  task automatic test_glitch();
    for (int n = 1; n <= 14; n++) begin
      tb_if.btn_in[1] = (n <= 3);
      tick();
      n_tests++;
      if (tb_if.btn_lvl[1] !== 1'b0 || tb_if.btn_pulse[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch cycle %0d: lvl=%b pulse=%b, want 0/0", n, tb_if.btn_lvl[1], tb_if.btn_pulse[1]);
      end
    end
    idle(4);
  endtask

  task automatic test_bounce();
    int pulses = 0;
    // Toggles every 2 cycles; the last transition (to 1) is at c=8, whose next edge is n=1.
    for (int c = 0; c < 10; c++) begin
      tb_if.btn_in[2] = ((c / 2) % 2 == 0);
      tick();
      if (tb_if.btn_pulse[2]) pulses++;
      n_tests++;
      if (tb_if.btn_lvl[2] !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_level cycle %0d: lvl=%b, want 0", c, tb_if.btn_lvl[2]);
      end
    end
    for (int n = 3; n <= 12; n++) begin
      tick();
      if (tb_if.btn_pulse[2]) pulses++;
      n_tests++;
      if (tb_if.btn_lvl[2] !== (n >= 6) || tb_if.btn_pulse[2] !== (n == 6)) begin
        n_fail++;
        $display("FAIL bounce_settle edge %0d: lvl=%b pulse=%b, want lvl=%b pulse=%b", n,
                 tb_if.btn_lvl[2], tb_if.btn_pulse[2], n >= 6, n == 6);
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL bounce_pulse_count: got %0d, want 1", pulses);
    end
    idle(10);
  endtask

  task automatic test_simultaneous();
    tb_if.btn_in = '1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      n_tests++;
      if (tb_if.btn_lvl !== ((n >= 6) ? 3'b111 : 3'b000) || tb_if.btn_pulse !== ((n == 6) ? 3'b111 : 3'b000)) begin
        n_fail++;
        $display("FAIL simultaneous edge %0d: lvl=%b pulse=%b, want lvl=%b pulse=%b", n,
                 tb_if.btn_lvl, tb_if.btn_pulse, (n >= 6) ? 3'b111 : 3'b000, (n == 6) ? 3'b111 : 3'b000);
      end
    end
    idle(10);
  endtask

  task automatic test_reset_hold();
    tb_if.btn_in[0] = 1'b1;
    repeat (9) tick();
    RSTN = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      n_tests++;
      if (tb_if.btn_lvl !== '0 || tb_if.btn_pulse !== '0) begin
        n_fail++;
        $display("FAIL reset_hold_in_reset cycle %0d: lvl=%b pulse=%b, want 000/000", n, tb_if.btn_lvl, tb_if.btn_pulse);
      end
    end
    RSTN = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      n_tests++;
      if (tb_if.btn_lvl[0] !== (n >= 6) || tb_if.btn_pulse[0] !== (n == 6)) begin
        n_fail++;
        $display("FAIL reset_hold_repress edge %0d: lvl=%b pulse=%b, want lvl=%b pulse=%b", n,
                 tb_if.btn_lvl[0], tb_if.btn_pulse[0], n >= 6, n == 6);
      end
    end
    idle(10);
  endtask

  task automatic test_autorepeat();
    int pulses = 0;
    int want   = 0;
    tb_if.btn_in[0] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (tb_if.btn_pulse[0]) pulses++;
      if (n >= 6 && exp_rep(n - 6)) want++;
      n_tests++;
      if (tb_if.btn_pulse[0] !== ((n >= 6) && exp_rep(n - 6))) begin
        n_fail++;
        $display("FAIL autorepeat edge %0d: pulse=%b, want %b", n, tb_if.btn_pulse[0], (n >= 6) && exp_rep(n - 6));
      end
    end
    n_tests++;
    if (pulses != want) begin
      n_fail++;
      $display("FAIL autorepeat_count: got %0d, want %0d", pulses, want);
    end
    idle(12);
  endtask

  task automatic test_random();
    int dur [NB];
    int rst_left = 0;
    for (int ch = 0; ch < NB; ch++) dur[ch] = 1;
    for (int c = 0; c < 800; c++) begin
      for (int ch = 0; ch < NB; ch++) begin
        dur[ch]--;
        if (dur[ch] <= 0) begin
          tb_if.btn_in[ch] = ~tb_if.btn_in[ch];
          dur[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 25));
        end
      end
      if (rst_left > 0) begin
        rst_left--;
      end else if ($urandom_range(0, 149) == 0) begin
        rst_left = $urandom_range(1, 3);
      end
      RSTN = (rst_left == 0);
      tick();
      n_tests++;
      if (tb_if.btn_lvl !== exp_lvl || tb_if.btn_pulse !== exp_pulse) begin
        n_fail++;
        $display("FAIL random cycle %0d: lvl=%b pulse=%b, want lvl=%b pulse=%b", c,
                 tb_if.btn_lvl, tb_if.btn_pulse, exp_lvl, exp_pulse);
      end
    end
    RSTN = 1'b1;
    idle(12);
  endtask

  initial begin
    RSTN = 1'b0;
    tb_if.btn_in = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_hold();
    test_autorepeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
